// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
// The fetch stage is the master: it raises IM_Req with a stable IM_Addr, and
// the memory answers with a one-cycle IM_Ack pulse carrying IM_Data.
interface fetch_stage_if;
  logic        IM_Req;
  logic [31:0] IM_Addr;
  logic        IM_Ack;
  logic [31:0] IM_Data;

  modport master (
    output IM_Req,
    output IM_Addr,
    input  IM_Ack,
    input  IM_Data
  );

  modport slave (
    input  IM_Req,
    input  IM_Addr,
    output IM_Ack,
    output IM_Data
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipe.
// Owns the PC, talks to a variable-latency instruction memory through a
// one-entry buffer, picks the next PC from sequential / ID / EX redirects and
// applies the hazard unit's stall and flush votes to the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter logic [31:0] ILLOP_ADDR = 32'h8000_0004,
  parameter logic [31:0] XADR_ADDR  = 32'h8000_0008
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         PCWrite,
  input  logic [2:0]         IF_ID_WRITE,
  input  logic [2:0]         IF_ID_Flush,
  input  logic [2:0]         ID_PCSrc,
  input  logic [31:0]        ID_JumpTarget,
  input  logic [31:0]        ID_JrTarget,
  input  logic               EX_BranchTaken,
  input  logic [31:0]        EX_BranchTarget,
  fetch_stage_if.master      im,
  output logic [31:0]        IF_ID_Instr,
  output logic [31:0]        IF_ID_PC4,
  output logic               IF_ID_Valid
);

  // IDLE: just out of reset, no request yet.
  // FETCH: request outstanding for req_addr_r.
  // BUFFERED: word captured while ID was stalled, no request.
  // DRAIN: a redirect arrived while a request was in flight; its data is dropped.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_BUFFERED = 2'd2,
    ST_DRAIN    = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] pc_r;
  logic [31:0] pc_nxt_s;
  logic [31:0] req_addr_r;
  logic [31:0] req_addr_nxt_s;
  logic [31:0] buf_r;
  logic [31:0] buf_nxt_s;
  logic        im_req_r;
  logic        im_req_nxt_s;

  logic [31:0] instr_r;
  logic [31:0] instr_nxt_s;
  logic [31:0] pc4_r;
  logic [31:0] pc4_nxt_s;
  logic        valid_r;
  logic        valid_nxt_s;

  logic        hold_s;
  logic        flush_s;
  logic        rd_ex_s;
  logic        rd_id_s;
  logic        rd_s;
  logic        id_redirect_s;
  logic [31:0] id_target_s;
  logic [31:0] target_s;
  logic [31:0] pc_plus4_s;

  logic        deliver_s;
  logic [31:0] deliver_data_s;
  logic [31:0] deliver_pc4_s;

  // Word-align a redirect target; instruction fetches are always 4-byte aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Any single dissenting vote stalls or flushes.
  assign hold_s     = ~(&PCWrite) | ~(&IF_ID_WRITE);
  assign flush_s    = ~(&IF_ID_Flush);
  assign rd_ex_s    = EX_BranchTaken;
  // An ID redirect is only trusted when ID is not stalled and EX is not overriding it.
  assign rd_id_s    = ~hold_s & ~rd_ex_s & id_redirect_s;
  assign rd_s       = rd_ex_s | rd_id_s;
  assign pc_plus4_s = pc_r + 32'd4;

  // Decode the ID-stage PC source into a redirect flag and its raw target.
  always_comb begin
    id_redirect_s = 1'b0;
    id_target_s   = 32'h0000_0000;
    case (ID_PCSrc)
      3'b010: begin
        id_redirect_s = 1'b1;
        id_target_s   = ID_JumpTarget;
      end
      3'b011: begin
        id_redirect_s = 1'b1;
        id_target_s   = ID_JrTarget;
      end
      3'b100: begin
        id_redirect_s = 1'b1;
        id_target_s   = ILLOP_ADDR;
      end
      3'b101: begin
        id_redirect_s = 1'b1;
        id_target_s   = XADR_ADDR;
      end
      default: begin
        id_redirect_s = 1'b0;
        id_target_s   = 32'h0000_0000;
      end
    endcase
  end

  // EX-stage branch target has priority over any ID-stage redirect.
  always_comb begin
    target_s = 32'h0000_0000;
    if (rd_ex_s) begin
      target_s = align_word(EX_BranchTarget);
    end else begin
      target_s = align_word(id_target_s);
    end
  end

  // Fetch FSM next-state, PC/request-address update and delivery decision.
  always_comb begin
    state_nxt_s    = state_r;
    pc_nxt_s       = pc_r;
    req_addr_nxt_s = req_addr_r;
    buf_nxt_s      = buf_r;
    deliver_s      = 1'b0;
    deliver_data_s = 32'h0000_0000;
    deliver_pc4_s  = 32'h0000_0000;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (rd_s) begin
          pc_nxt_s = target_s;
          if (im.IM_Ack) begin
            // Returned word belongs to the wrong path; restart at the target.
            req_addr_nxt_s = target_s;
          end else begin
            // Request still in flight; its answer must be swallowed first.
            state_nxt_s = ST_DRAIN;
          end
        end else if (im.IM_Ack) begin
          if (!hold_s) begin
            deliver_s      = 1'b1;
            deliver_data_s = im.IM_Data;
            deliver_pc4_s  = req_addr_r + 32'd4;
            pc_nxt_s       = pc_plus4_s;
            req_addr_nxt_s = pc_plus4_s;
          end else begin
            buf_nxt_s   = im.IM_Data;
            state_nxt_s = ST_BUFFERED;
          end
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_BUFFERED: begin
        if (rd_s) begin
          pc_nxt_s       = target_s;
          req_addr_nxt_s = target_s;
          state_nxt_s    = ST_FETCH;
        end else if (!hold_s) begin
          deliver_s      = 1'b1;
          deliver_data_s = buf_r;
          deliver_pc4_s  = pc_plus4_s;
          pc_nxt_s       = pc_plus4_s;
          req_addr_nxt_s = pc_plus4_s;
          state_nxt_s    = ST_FETCH;
        end else begin
          state_nxt_s = ST_BUFFERED;
        end
      end
      ST_DRAIN: begin
        if (rd_s) begin
          pc_nxt_s = target_s;
        end else begin
          pc_nxt_s = pc_r;
        end
        if (im.IM_Ack) begin
          // Stale word dropped; the next request goes to the newest PC.
          if (rd_s) begin
            req_addr_nxt_s = target_s;
          end else begin
            req_addr_nxt_s = pc_r;
          end
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // A request is outstanding exactly in FETCH and DRAIN.
  always_comb begin
    im_req_nxt_s = 1'b0;
    if ((state_nxt_s == ST_FETCH) || (state_nxt_s == ST_DRAIN)) begin
      im_req_nxt_s = 1'b1;
    end else begin
      im_req_nxt_s = 1'b0;
    end
  end

  // IF/ID next value: flush beats hold, hold beats delivery, otherwise a bubble.
  always_comb begin
    instr_nxt_s = instr_r;
    pc4_nxt_s   = pc4_r;
    valid_nxt_s = valid_r;
    if (flush_s) begin
      instr_nxt_s = 32'h0000_0000;
      valid_nxt_s = 1'b0;
    end else if (hold_s) begin
      instr_nxt_s = instr_r;
      pc4_nxt_s   = pc4_r;
      valid_nxt_s = valid_r;
    end else if (deliver_s) begin
      instr_nxt_s = deliver_data_s;
      pc4_nxt_s   = deliver_pc4_s;
      valid_nxt_s = 1'b1;
    end else begin
      instr_nxt_s = 32'h0000_0000;
      valid_nxt_s = 1'b0;
    end
  end

  // Fetch state, PC, request address, buffer and request strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      pc_r       <= RESET_PC;
      req_addr_r <= RESET_PC;
      buf_r      <= 32'h0000_0000;
      im_req_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      pc_r       <= pc_nxt_s;
      req_addr_r <= req_addr_nxt_s;
      buf_r      <= buf_nxt_s;
      im_req_r   <= im_req_nxt_s;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_r <= 32'h0000_0000;
      pc4_r   <= 32'h0000_0000;
      valid_r <= 1'b0;
    end else begin
      instr_r <= instr_nxt_s;
      pc4_r   <= pc4_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  assign im.IM_Req   = im_req_r;
  assign im.IM_Addr  = req_addr_r;
  assign IF_ID_Instr = instr_r;
  assign IF_ID_PC4   = pc4_r;
  assign IF_ID_Valid = valid_r;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline. It owns the PC, issues requests to a variable-latency instruction memory, and selects the next PC from sequential, ID-stage (jump/jr/exception) and EX-stage (taken branch) redirects. It stalls and flushes under control of the 3-bit vote vectors driven by the hazard detection unit, and it feeds the ID stage.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000: PC after reset
- ILLOP_ADDR, 32'h8000_0004: target for ID_PCSrc = 3'b100
- XADR_ADDR, 32'h8000_0008: target for ID_PCSrc = 3'b101

Ports:
- clk  in  1  clock. Every register updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- PCWrite  in  3  hazard votes. Each bit is 1 to allow the PC to advance.
- IF_ID_WRITE  in  3  hazard votes. Each bit is 1 to allow IF/ID to load.
- IF_ID_Flush  in  3  hazard votes. Each bit is 0 to request a flush.
- ID_PCSrc  in  3  PC source decoded in ID.
- ID_JumpTarget  in  32  j/jal target.
- ID_JrTarget  in  32  jr/jalr register value.
- EX_BranchTaken  in  1  the branch in EX is resolved taken.
- EX_BranchTarget  in  32  branch target.
- IM_Req  out  1  instruction memory request.
- IM_Addr  out  32  request address.
- IM_Ack  in  1  one-cycle pulse. IM_Data is valid in that cycle.
- IM_Data  in  32  instruction word.
- IF_ID_Instr  out  32  instruction presented to ID.
- IF_ID_PC4  out  32  address of that instruction + 4.
- IF_ID_Valid  out  1  0 = bubble.

## Operation
- Derived signals:
  - hold = ~&PCWrite | ~&IF_ID_WRITE
  - flush = ~&IF_ID_Flush
  - rd_ex = EX_BranchTaken
  - rd_id = ~hold & ~rd_ex & ID_PCSrc ∈ {010, 011, 100, 101}
  - rd = rd_ex | rd_id
- Target priority: EX_BranchTarget, then ID_JumpTarget (010), ID_JrTarget (011), ILLOP_ADDR (100), XADR_ADDR (101). Bits [1:0] of the target are forced to 0. A redirect from EX is taken even when hold = 1.
- Registers:
  - PC: the next fetch address.
  - Req_Addr: drives IM_Addr.
  - Buf: one-entry instruction buffer.
  - State: IDLE, FETCH, BUFFERED, DRAIN.
- IM_Req = 1 in FETCH and DRAIN. IM_Addr = Req_Addr and stays stable while IM_Req = 1.
- IDLE: go to FETCH unconditionally on the next edge.
- FETCH:
  - rd & IM_Ack: the returned data is discarded. PC and Req_Addr take the target. Stay in FETCH.
  - rd & ~IM_Ack: PC takes the target. Go to DRAIN.
  - ~rd & IM_Ack & ~hold: the instruction is delivered. PC and Req_Addr take PC + 4.
  - ~rd & IM_Ack & hold: Buf takes IM_Data. Go to BUFFERED.
  - Otherwise, stay in FETCH.
- BUFFERED:
  - rd: Buf is discarded. PC and Req_Addr take the target. Go to FETCH.
  - ~hold: Buf is delivered. PC and Req_Addr take PC + 4. Go to FETCH.
  - hold: stay in BUFFERED.
- DRAIN:
  - IM_Ack: the data is discarded. Req_Addr takes PC. Go to FETCH.
  - A further rd while in DRAIN updates PC only.
- IF/ID update, in priority order:
  1. flush: Instr = 0, Valid = 0, PC4 held.
  2. hold: all fields held.
  3. An instruction is delivered this cycle: Instr = data, PC4 = Req_Addr + 4 (or PC + 4 from BUFFERED), Valid = 1.
  4. Otherwise: bubble (Instr = 0, Valid = 0).
- A flush without rd affects only IF/ID, not the FSM or PC.
- PC + 4 wraps modulo 2^32.

## Timing
- Reset (asynchronous, while reset = 0):
  - State = IDLE.
  - PC = Req_Addr = RESET_PC.
  - Buf = 0.
  - IF_ID_Instr = 0, IF_ID_PC4 = 0, IF_ID_Valid = 0.
  - IM_Req = 0.
- First IM_Req rises one cycle after reset deasserts.
- IM_Ack may assert in any cycle with IM_Req = 1, including the first.
- Zero-wait memory sustains one instruction per cycle. Latency from IM_Ack to IF_ID_Valid is one edge.
- A redirect in cycle N puts the target on IM_Addr in cycle N+1 if no fetch is outstanding. Otherwise it appears in the cycle after the draining IM_Ack.
- Reset asserted mid-fetch or mid-drain aborts immediately. An IM_Ack that arrives later in IDLE is ignored.

## Test plan
- Reset and zero-wait ack: after reset deasserts, IM_Addr = 0x80000000, 0x80000004, 0x80000008 on consecutive cycles. IF_ID_PC4 = 0x80000004, 0x80000008, … with Valid = 1 every cycle.
- Load-use stall:
  - Stimulus: PCWrite = IF_ID_WRITE = 3'b110 for 2 cycles while an ack arrives.
  - Response: the data is captured in BUFFERED and IM_Req = 0. IF/ID holds its value. When hold clears, the buffered word is delivered and the next request uses PC + 4.
- ID jump:
  - Stimulus: ID_PCSrc = 010, ID_JumpTarget = 0x00400103, IF_ID_Flush = 3'b101.
  - Response: IF/ID is bubbled. The next IM_Addr = 0x00400100.
- EX branch during a 3-cycle memory wait:
  - Stimulus: EX_BranchTaken with target 0x00400040 in the first wait cycle.
  - Response: DRAIN. The late ack's data never reaches IF/ID. IM_Addr = 0x00400040 after the ack.
- Branch in EX concurrent with load-use hold and ID_PCSrc = 011:
  - Response: the EX target wins and the jr is ignored. IF/ID is flushed (flush beats hold).
- Wrap: a PC of 0xFFFFFFFC followed by an ack gives a next IM_Addr of 0x00000000. Also check that ID_PCSrc = 100 and 101 redirect to 0x80000004 and 0x80000008.
